nonce_dispatcher: RTL

Issues the nonce search space for one block to the core array, one broadcast beat at a time. It is the sending side of the broadcast stream that the result decoder counts. Each accepted beat carries a 32-bit nonce base; core `i` tests `base + i`. Consecutive beats advance the base by `NUM_CORES`. A block ends after `BROADCAST_CNT` beats, or earlier when the decoder reports a hit.

---
 rtl/bc_pkg.sv | 12 +
 rtl/nonce_beat_counter.sv | 38 +++
 rtl/nonce_dispatcher.sv | 99 +++++++++
 3 files changed

// File: rtl/bc_pkg.sv
// Broadcast-stream definitions shared by the nonce dispatcher and the result decoder.
package bc_pkg;

    localparam int NONCE_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DONE
    } dispatch_state_t;

endpackage

// File: rtl/nonce_beat_counter.sv
// Beat index and nonce-base accumulator for the beat currently presented to the cores.
module nonce_beat_counter
    import bc_pkg::*;
#(
    parameter int                 NUM_CORES     = 10,
    parameter int                 BROADCAST_CNT = 100,
    parameter logic [NONCE_W-1:0] NONCE_START   = 32'h0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               advance,
    output logic [NONCE_W-1:0] nonce_base,
    output logic               last
);

    localparam int CNT_W = $clog2(BROADCAST_CNT + 1);

    logic [CNT_W-1:0] beat_cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt   <= '0;
            nonce_base <= NONCE_START;
        end else if (load) begin
            beat_cnt   <= '0;
            nonce_base <= NONCE_START;
        end else if (advance) begin
            beat_cnt   <= beat_cnt + CNT_W'(1);
            // The accumulator wraps modulo 2^32 by design.
            nonce_base <= nonce_base + NONCE_W'(NUM_CORES);
        end
    end

    assign last = (beat_cnt == CNT_W'(BROADCAST_CNT - 1));

endmodule

// File: rtl/nonce_dispatcher.sv
// Sends one block's nonce search space to the core array as a valid/ready beat stream.
module nonce_dispatcher
    import bc_pkg::*;
#(
    parameter int                 NUM_CORES     = 10,
    parameter int                 BROADCAST_CNT = 100,
    parameter logic [NONCE_W-1:0] NONCE_START   = 32'h0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               newblock_i,
    input  logic               abort_i,
    input  logic               ready_i,
    output logic               valid_o,
    output logic               newblock_o,
    output logic [NONCE_W-1:0] nonce_base_o,
    output logic               busy_o,
    output logic               done_o
);

    dispatch_state_t state, state_next;
    logic            load;
    logic            advance;
    logic            last;
    logic            xfer;
    logic            newblock_next;

    assign xfer = valid_o & ready_i;

    // The accumulator register itself drives nonce_base_o, so the output stays registered.
    nonce_beat_counter #(
        .NUM_CORES    (NUM_CORES),
        .BROADCAST_CNT(BROADCAST_CNT),
        .NONCE_START  (NONCE_START)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .advance   (advance),
        .nonce_base(nonce_base_o),
        .last      (last)
    );

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        advance    = 1'b0;
        case (state)
            IDLE: begin
                if (newblock_i) begin
                    state_next = ISSUE;
                    load       = 1'b1;
                end
            end
            ISSUE: begin
                // A restart abandons the current block silently; it outranks abort.
                if (newblock_i) begin
                    load = 1'b1;
                end else if (xfer && last) begin
                    state_next = DONE;
                end else begin
                    advance = xfer;
                    if (abort_i) state_next = DONE;
                end
            end
            DONE: begin
                if (newblock_i) begin
                    state_next = ISSUE;
                    load       = 1'b1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (load)                                newblock_next = 1'b1;
        else if (state_next == ISSUE && !xfer)   newblock_next = newblock_o;
        else                                     newblock_next = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            valid_o    <= 1'b0;
            newblock_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else begin
            state      <= state_next;
            valid_o    <= (state_next == ISSUE);
            newblock_o <= newblock_next;
            busy_o     <= (state_next == ISSUE);
            done_o     <= (state_next == DONE);
        end
    end

endmodule
